filter_spad_writer: RTL and testbench
=====================================

Name: filter_spad_writer

Overview:
- Write-side companion to the PE filter read counter. Accepts filter weights from the GLB/NoC over a valid/ready stream and writes them into a two-bank (ping-pong) filter scratchpad inside one PE.
- Hands each completed bank to the PE read side through a bank-valid/release handshake, so filter N+1 loads while filter N is consumed.

Parameters:
- DATA_W, 16, weight width in bits
- ADDR_W, 3, word address width within one bank; bank depth is 2**ADDR_W

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rstn  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; returns the block to its reset state
- en  input  1  enables loading; sampled only in IDLE and at bank boundaries
- filter_len  input  ADDR_W  words per filter; legal range 1..2**ADDR_W-1
- in_valid  input  1  weight stream valid
- in_ready  output  1  weight stream ready
- in_data  input  DATA_W  weight
- spad_we  output  1  scratchpad write enable (registered)
- spad_waddr  output  ADDR_W+1  {bank, word index}
- spad_wdata  output  DATA_W  registered copy of in_data
- rd_valid  output  1  bank rd_bank holds a complete filter
- rd_bank  output  1  bank the read side must use
- rd_release  input  1  one-cycle pulse: read side is finished with rd_bank
- busy  output  1  state != IDLE

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; wb=0, wi=0, rb=0, full=2'b00, len_q=0.
  - All outputs 0.
- clear=1 (synchronous) has the same effect as reset and takes priority over every other event in that cycle. A spad_we already registered from the previous cycle still completes; no new write is issued.
- States:
  - IDLE: go to FILL when en=1 and filter_len!=0.
  - FILL: in_ready = !full[wb].
    - On the last word of a bank, go to STALL if full[!wb]=1, or to IDLE if en=0. Otherwise stay in FILL.
    - en=0 while wi==0 and no handshake is occurring: go to IDLE.
  - STALL: in_ready=0. Go to FILL on the cycle after rd_release frees bank wb.
- Handshake: a transfer occurs when in_valid && in_ready.
  - On a transfer with wi==0, len_q <= filter_len. Changes to filter_len mid-bank are ignored.
  - Write latency is 1 cycle: the next cycle has spad_we=1, spad_waddr={wb,wi}, spad_wdata=in_data. spad_we=0 in every other cycle.
  - wi increments on each transfer.
  - On the transfer where wi==len_q-1 (compared against filter_len when wi==0, so len=1 works):
    - wi<=0, full[wb]<=1, wb<=~wb.
    - rd_valid rises 1 cycle after the final transfer, in the same cycle as the final spad_we, so data is visible before the reader indexes it.
- Read side:
  - rd_valid = full[rb].
  - rd_release while rd_valid=1: full[rb]<=0, rb<=~rb.
  - rd_release while rd_valid=0 is ignored (no state change).
- Simultaneous events:
  - A bank completion and a release of the other bank in the same cycle both take effect.
  - Set and clear of the same bank cannot coincide, because set requires !full and clear requires full.
- Wrap-around: wi never reaches 2**ADDR_W. filter_len=0 keeps the block in IDLE with in_ready=0.
- in_ready is combinational from registered state only; it never depends on in_valid.

Decomposition:
- Shared Eyeriss package:
  - FSM state enum {IDLE, FILL, STALL}
  - default DATA_W and ADDR_W constants (shared with the filter read counter)
- Sub-module: filter_bank_tracker, which holds the full[1:0] flags, the rb pointer, and the release logic.
- The FSM, wb/wi counters, and the write register stay in the top module.

Test Plan:
- Reset, then en=1, filter_len=3, stream 0xA1,0xA2,0xA3 back-to-back: spad writes {0,0..2} appear on cycles T+1..T+3; rd_valid=1, rd_bank=0 on the 3rd write cycle; wb=1.
- Fill both banks (len=3) with no release: in_ready=0 and state=STALL after 6 words. Pulse rd_release: rd_bank=1, and in_ready=1 on the next cycle.
- filter_len=1: each single transfer sets full and toggles wb. Change filter_len to 5 mid-bank when len=3: the bank still completes after 3 words.
- Release bank 0 in the same cycle as the final word of bank 1: full ends 2'b10, rb=1, wb=0, state=FILL.
- clear asserted after 2 of 3 words: next cycle wi=0, full=0, rd_valid=0, spad_we=0. Async rstn low mid-STALL: outputs 0 immediately, with no clock edge needed.
- rd_release with rd_valid=0: no change. in_valid held low in FILL: no spad_we is issued.

Source files
------------

// File: rtl/filter_spad_writer_pkg.sv
// Shared package for the PE filter scratchpad datapath. Holds the writer
// FSM encoding and the default widths used by both the writer and the read counter.
package filter_spad_writer_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/filter_spad_writer_if.sv
// Bus bundle for the filter writer: the input weight stream, the scratchpad
// write port and the bank handoff to the read side.
interface filter_spad_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              spad_we;
  logic [ADDR_W:0]   spad_waddr;
  logic [DATA_W-1:0] spad_wdata;
  logic              rd_valid;
  logic              rd_bank;
  logic              rd_release;

  // Writer side.
  modport master (
    input  in_valid, in_data, rd_release,
    output in_ready, spad_we, spad_waddr, spad_wdata, rd_valid, rd_bank
  );

  // Producer/consumer side (stream source, scratchpad and read side).
  modport slave (
    output in_valid, in_data, rd_release,
    input  in_ready, spad_we, spad_waddr, spad_wdata, rd_valid, rd_bank
  );
endinterface

// File: rtl/filter_spad_writer_tracker.sv
// Ping-pong bank ownership: one full flag per bank plus the read pointer.
// A release only counts while the bank under the read pointer is full.
module filter_bank_tracker (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       i_set,
  input  logic       i_set_bank,
  input  logic       i_release,
  output logic [1:0] o_full,
  output logic       o_rb,
  output logic       o_rel_fire
);
  logic [1:0] r_full;
  logic       r_rb;
  logic       w_rel_fire;

  assign w_rel_fire = i_release & r_full[r_rb];

  // Set on bank completion, clear on release; both may land in one cycle
  // because they always target different banks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= 2'b00;
      r_rb   <= 1'b0;
    end else if (clear) begin
      r_full <= 2'b00;
      r_rb   <= 1'b0;
    end else begin
      if (i_set) r_full[i_set_bank] <= 1'b1;
      if (w_rel_fire) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end

  assign o_full     = r_full;
  assign o_rb       = r_rb;
  assign o_rel_fire = w_rel_fire;
endmodule

// File: rtl/filter_spad_writer.sv
// Write side of the PE filter scratchpad. Streams weights into the bank
// being filled, then hands the completed bank to the reader.
module filter_spad_writer
  import filter_spad_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               en,
  input  logic [ADDR_W-1:0]  filter_len,
  output logic               busy,
  filter_spad_writer_if.master bus
);
  fsm_state_e        r_state;
  logic              r_wb;
  logic [ADDR_W-1:0] r_wi;
  logic [ADDR_W-1:0] r_len_q;
  logic              r_we;
  logic [ADDR_W:0]   r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_full;
  logic              w_rb;
  logic              w_rel_fire;
  logic              w_ready;
  logic              w_xfer;
  logic              w_last;
  logic [ADDR_W-1:0] w_len_eff;
  logic              w_other_full;
  logic              w_stall_rel;

  filter_bank_tracker u_trk (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .i_set      (w_last),
    .i_set_bank (r_wb),
    .i_release  (bus.rd_release),
    .o_full     (w_full),
    .o_rb       (w_rb),
    .o_rel_fire (w_rel_fire)
  );

  assign w_ready   = (r_state == FILL) && !w_full[r_wb];
  assign w_xfer    = bus.in_valid && w_ready;
  // First word of a bank latches the length, so compare against the live input then.
  assign w_len_eff = (r_wi == '0) ? filter_len : r_len_q;
  assign w_last    = w_xfer && (r_wi == (w_len_eff - ADDR_W'(1)));
  // Other bank counts as free if it is being released this same cycle.
  assign w_other_full = w_full[~r_wb] && !(w_rel_fire && (w_rb == ~r_wb));
  assign w_stall_rel  = w_rel_fire && (w_rb == r_wb);

  // Control FSM with the bank/word counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_wb    <= 1'b0;
      r_wi    <= '0;
      r_len_q <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_wb    <= 1'b0;
      r_wi    <= '0;
      r_len_q <= '0;
    end else begin
      case (r_state)
        IDLE: if (en && (filter_len != '0)) r_state <= FILL;
        FILL: begin
          if (w_xfer) begin
            if (r_wi == '0) r_len_q <= filter_len;
            if (w_last) begin
              r_wi <= '0;
              r_wb <= ~r_wb;
              if (w_other_full) r_state <= STALL;
              else if (!en)     r_state <= IDLE;
            end else begin
              r_wi <= r_wi + ADDR_W'(1);
            end
          end else if (!en && (r_wi == '0)) begin
            r_state <= IDLE;
          end
        end
        STALL: if (w_stall_rel || !w_full[r_wb]) r_state <= FILL;
        default: r_state <= IDLE;
      endcase
    end
  end

  // One-cycle write pipeline into the scratchpad.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (clear) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr <= {r_wb, r_wi};
        r_wdata <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.spad_we    = r_we;
  assign bus.spad_waddr = r_waddr;
  assign bus.spad_wdata = r_wdata;
  assign bus.rd_valid   = w_full[w_rb];
  assign bus.rd_bank    = w_rb;
  assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_filter_spad_writer.sv
// Directed bench for filter_spad_writer: ping-pong fill, stall/release,
// length handling, clear and async reset.
module tb_filter_spad_writer;
  import filter_spad_writer_pkg::*;

  logic       clk;
  logic       rstn;
  logic       clear;
  logic       en;
  logic [2:0] filter_len;
  logic       busy;
  int         n_chk;
  int         n_fail;

  filter_spad_writer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  filter_spad_writer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .en         (en),
    .filter_len (filter_len),
    .busy       (busy),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clk = 0; rstn = 0; clear = 0; en = 0; filter_len = 3'd0;
    bus.in_valid = 0; bus.in_data = 16'h0; bus.rd_release = 0;
    #3;
    chk("rst_we",    32'(bus.spad_we), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_rdv",   32'(bus.rd_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    #9 rstn = 1;
    tick();

    // Bank 0, len 3
    en = 1; filter_len = 3'd3;
    tick();
    chk("fill_ready", 32'(bus.in_ready), 1);
    send(16'h00A1);
    chk("w0_we", 32'(bus.spad_we), 1);
    chk("w0_addr", 32'(bus.spad_waddr), 32'h0);
    chk("w0_data", 32'(bus.spad_wdata), 32'hA1);
    chk("w0_rdv", 32'(bus.rd_valid), 0);
    send(16'h00A2);
    chk("w1_addr", 32'(bus.spad_waddr), 32'h1);
    chk("w1_data", 32'(bus.spad_wdata), 32'hA2);
    send(16'h00A3);
    chk("w2_addr", 32'(bus.spad_waddr), 32'h2);
    chk("w2_data", 32'(bus.spad_wdata), 32'hA3);
    chk("b0_rdv", 32'(bus.rd_valid), 1);
    chk("b0_rdbank", 32'(bus.rd_bank), 0);
    chk("b0_wb", 32'(dut.r_wb), 1);

    // Bank 1 with no release -> STALL
    send(16'h00B1);
    send(16'h00B2);
    send(16'h00B3);
    chk("b1_addr", 32'(bus.spad_waddr), 32'hA);
    chk("stall_ready", 32'(bus.in_ready), 0);
    chk("stall_state", 32'(dut.r_state), 32'(STALL));
    chk("stall_full", 32'(dut.u_trk.r_full), 32'h3);
    bus.in_valid = 0;
    bus.rd_release = 1;
    tick();
    bus.rd_release = 0;
    chk("rel_rdbank", 32'(bus.rd_bank), 1);
    chk("rel_ready", 32'(bus.in_ready), 1);
    chk("rel_state", 32'(dut.r_state), 32'(FILL));

    // Release bank 1 as well
    bus.rd_release = 1;
    tick();
    bus.rd_release = 0;
    chk("rel2_rdv", 32'(bus.rd_valid), 0);

    // Bank 0 again, then bank 1 with a mid-bank length change and a
    // release of bank 0 on the final word
    send(16'h00C1);
    send(16'h00C2);
    send(16'h00C3);
    send(16'h00D1);
    filter_len = 3'd5;
    send(16'h00D2);
    chk("len_mid_full", 32'(dut.u_trk.r_full), 32'h1);
    bus.rd_release = 1;
    send(16'h00D3);
    bus.rd_release = 0;
    bus.in_valid = 0;
    chk("sim_full", 32'(dut.u_trk.r_full), 32'h2);
    chk("sim_rb", 32'(bus.rd_bank), 1);
    chk("sim_wb", 32'(dut.r_wb), 0);
    chk("sim_state", 32'(dut.r_state), 32'(FILL));
    chk("sim_addr", 32'(bus.spad_waddr), 32'hA);

    // in_valid low while FILL: no writes
    tick();
    chk("idle_we0", 32'(bus.spad_we), 0);
    tick();
    chk("idle_we1", 32'(bus.spad_we), 0);

    // Release bank 1, then a release with nothing valid
    bus.rd_release = 1;
    tick();
    chk("rel3_rdv", 32'(bus.rd_valid), 0);
    tick();
    bus.rd_release = 0;
    chk("norel_rb", 32'(bus.rd_bank), 0);
    chk("norel_full", 32'(dut.u_trk.r_full), 0);

    // filter_len = 1
    filter_len = 3'd1;
    send(16'h00E1);
    chk("l1_full0", 32'(dut.u_trk.r_full), 32'h1);
    chk("l1_wb0", 32'(dut.r_wb), 1);
    chk("l1_addr0", 32'(bus.spad_waddr), 32'h0);
    send(16'h00E2);
    bus.in_valid = 0;
    chk("l1_full1", 32'(dut.u_trk.r_full), 32'h3);
    chk("l1_wb1", 32'(dut.r_wb), 0);
    chk("l1_addr1", 32'(bus.spad_waddr), 32'h8);
    chk("l1_state", 32'(dut.r_state), 32'(STALL));
    bus.rd_release = 1;
    tick();
    tick();
    bus.rd_release = 0;
    chk("l1_drain", 32'(dut.u_trk.r_full), 0);

    // en low at a bank boundary -> IDLE
    en = 0;
    tick();
    chk("en0_busy", 32'(busy), 0);

    // filter_len = 0 stays in IDLE
    en = 1; filter_len = 3'd0;
    tick();
    tick();
    chk("len0_busy", 32'(busy), 0);
    chk("len0_ready", 32'(bus.in_ready), 0);

    // clear after 2 of 3 words
    filter_len = 3'd3;
    tick();
    send(16'h00F1);
    send(16'h00F2);
    chk("clr_pre_we", 32'(bus.spad_we), 1);
    clear = 1;
    tick();
    clear = 0;
    bus.in_valid = 0;
    chk("clr_wi", 32'(dut.r_wi), 0);
    chk("clr_full", 32'(dut.u_trk.r_full), 0);
    chk("clr_rdv", 32'(bus.rd_valid), 0);
    chk("clr_we", 32'(bus.spad_we), 0);
    chk("clr_busy", 32'(busy), 0);

    // Async reset mid-STALL
    tick();
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i));
    chk("ar_state", 32'(dut.r_state), 32'(STALL));
    chk("ar_we_pre", 32'(bus.spad_we), 1);
    #2 rstn = 0;
    #1;
    chk("ar_we", 32'(bus.spad_we), 0);
    chk("ar_rdv", 32'(bus.rd_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_addr", 32'(bus.spad_waddr), 0);
    chk("ar_data", 32'(bus.spad_wdata), 0);
    bus.in_valid = 0;
    #1 rstn = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
